// File: rtl/nap_scheduler.sv
// Nap countdown sequencer driving the alarm blinker start/stop.
// Optional macro NAP_PAUSE_EN adds a pause_i input that stalls the NAP/SNOOZE countdown.
module nap_scheduler #(
    parameter int TICK_DIV     = 1000,
    parameter int CNT_W        = 16,
    parameter int SNOOZE_TIME  = 300,
    parameter int MAX_SNOOZE   = 3,
    parameter int RING_TIMEOUT = 600
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [CNT_W-1:0] duration_i,
    input  logic             arm_i,
    input  logic             cancel_i,
    input  logic             snooze_i,
    input  logic             dismiss_i,
`ifdef NAP_PAUSE_EN
    input  logic             pause_i,
`endif
    output logic             alarm_start_o,
    output logic             alarm_stop_o,
    output logic [CNT_W-1:0] remaining_o,
    output logic [1:0]       snooze_cnt_o,
    output logic             ringing_o
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(RING_TIMEOUT + 1);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0]    RING_LAST  = RW'(RING_TIMEOUT - 1);
    localparam logic [1:0]       SNZ_MAX    = 2'(MAX_SNOOZE);
    localparam logic [CNT_W-1:0] SNZ_LOAD   = CNT_W'(SNOOZE_TIME);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_NAP    = 2'd1,
        S_SNOOZE = 2'd2,
        S_RING   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [RW-1:0]    ring_cnt_q, ring_cnt_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [1:0]       snooze_cnt_q, snooze_cnt_d;
    logic             alarm_start_q, alarm_stop_q, ringing_q;
    logic             counting;
    logic             tick;
    logic             entering;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        snooze_cnt_d = snooze_cnt_q;
        counting     = (state_q != S_IDLE);
`ifdef NAP_PAUSE_EN
        if (pause_i && (state_q == S_NAP || state_q == S_SNOOZE)) begin
            counting = 1'b0;
        end
`endif
        tick = counting && (presc_q == PRESC_LAST);

        case (state_q)
            S_IDLE: begin
                if (arm_i) begin
                    snooze_cnt_d = 2'd0;
                    if (duration_i != '0) begin
                        state_d     = S_NAP;
                        remaining_d = duration_i;
                    end else begin
                        state_d     = S_RING;
                        remaining_d = '0;
                    end
                end
            end
            S_NAP, S_SNOOZE: begin
                // dismiss only aborts a snooze; during the nap itself it is meaningless
                if (cancel_i || (dismiss_i && state_q == S_SNOOZE)) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end else if (tick) begin
                    if (remaining_q <= CNT_W'(1)) begin
                        state_d     = S_RING;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end
            end
            S_RING: begin
                if (dismiss_i) begin
                    state_d = S_IDLE;
                end else if (snooze_i && (snooze_cnt_q < SNZ_MAX)) begin
                    state_d      = S_SNOOZE;
                    remaining_d  = SNZ_LOAD;
                    snooze_cnt_d = snooze_cnt_q + 2'd1;
                end else if (tick && (ring_cnt_q == RING_LAST)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                remaining_d = '0;
            end
        endcase

        entering = (state_d != state_q);

        // prescaler restarts on every state entry so the first tick is a full period away
        if (entering || state_d == S_IDLE) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end else begin
            presc_d = presc_q;
        end

        if (entering) begin
            ring_cnt_d = '0;
        end else if (state_q == S_RING && tick) begin
            ring_cnt_d = ring_cnt_q + RW'(1);
        end else begin
            ring_cnt_d = ring_cnt_q;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            ring_cnt_q    <= '0;
            remaining_q   <= '0;
            snooze_cnt_q  <= 2'd0;
            alarm_start_q <= 1'b0;
            alarm_stop_q  <= 1'b1;
            ringing_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            ring_cnt_q    <= ring_cnt_d;
            remaining_q   <= remaining_d;
            snooze_cnt_q  <= snooze_cnt_d;
            alarm_start_q <= (state_d == S_RING) && (state_q != S_RING);
            alarm_stop_q  <= (state_d != S_RING);
            ringing_q     <= (state_d == S_RING);
        end
    end

    assign alarm_start_o = alarm_start_q;
    assign alarm_stop_o  = alarm_stop_q;
    assign remaining_o   = remaining_q;
    assign snooze_cnt_o  = snooze_cnt_q;
    assign ringing_o     = ringing_q;

endmodule
